sa_feeder: RTL and testbench
============================

# sa_feeder

Front-end sequencer for `systolic_array`. It takes row-aligned weight vectors and activation vectors over valid/ready streams and drives the array's load and compute ports. It loads the stationary weights one row per cycle, applies the triangular input skew (row r delayed r cycles), and flushes the pipeline with zeros after the last activation. It also emits per-column valid flags aligned to `out_psum_vec`, so the downstream collector needs no latency knowledge.

## Interface
- `ARRAY_ROW`, default `` `ARRAY_ROW `` (12): rows, i.e. the activation vector length.
- `ARRAY_COL`, default `` `ARRAY_COL ``: columns, i.e. the weight vector length.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): signed int8 element width.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `w_valid`  in  1  weight beat valid.
- `w_ready`  out  1  weight beat accepted when `w_valid & w_ready`.
- `w_data`  in  ARRAY_COL*DATA_WIDTH  one weight row; beat i targets array row i.
- `a_valid`  in  1  activation beat valid.
- `a_ready`  out  1  activation beat accepted when `a_valid & a_ready`.
- `a_data`  in  ARRAY_ROW*DATA_WIDTH  one token; element r is at `[r*DATA_WIDTH +: DATA_WIDTH]`.
- `a_last`  in  1  marks the final token of a sequence; sampled on acceptance.
- `row_load_en`  out  ARRAY_ROW  one-hot weight-load strobe to the array.
- `in_weight_vec`  out  ARRAY_COL*DATA_WIDTH  weight row to the array.
- `en_compute`  out  1  array compute enable.
- `in_act_vec`  out  ARRAY_ROW*DATA_WIDTH  skewed activations to the array.
- `col_valid`  out  ARRAY_COL  bit c is high when `out_psum_vec` column c holds a real token result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of the drain.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN.
- **IDLE**
  - Both readies are low. `en_compute` is 0.
  - If `w_valid`, go to LOAD_W. Otherwise, if `a_valid`, go to STREAM. Weights win if both are asserted.
- **LOAD_W**
  - `w_ready` is 1. A 0..ARRAY_ROW-1 counter tracks beats.
  - Beat i accepted at edge N: `row_load_en = 1<<i` and `in_weight_vec = w_data` are registered and presented during cycle N.
  - After beat ARRAY_ROW-1, return to IDLE. `row_load_en` and `in_weight_vec` go to 0 in the following cycle.
  - Gaps in `w_valid` are allowed; the counter holds across them.
- **STREAM**
  - `a_ready` is 1 and `en_compute` is 1.
  - Each cycle, a stage-0 valid bit is set to `a_valid & a_ready`. Element r of the accepted token enters a delay line of depth r.
  - A cycle without a beat inserts a zero bubble. The array keeps running; bubbles produce `col_valid` = 0.
  - On acceptance with `a_last` = 1, go to DRAIN.
- **DRAIN**
  - `a_ready` is 0, `en_compute` is 1, and zeros are injected.
  - A counter runs ARRAY_ROW+ARRAY_COL-1 cycles. In the final cycle, `done` = 1. Next state is IDLE.
- **Skew:** `in_act_vec` row r carries token element r exactly r cycles after row 0 carries it. Row 0 carries it in the cycle following its acceptance edge.
- **Valid tracking:** a shift register of depth ARRAY_ROW+ARRAY_COL-1. `col_valid[c]` equals the stage-0 valid bit delayed ARRAY_ROW+c cycles.
- Weights are never loaded while STREAM or DRAIN is active. `w_ready` is 0 there.
- An asynchronous reset mid-operation clears every register, all delay lines and the valid pipeline. The state returns to IDLE. Nothing is flushed.

## Timing
- Reset values: all outputs 0. This covers `w_ready`, `a_ready`, `row_load_en`, `in_weight_vec`, `en_compute`, `in_act_vec`, `col_valid`, `busy` and `done`.
- IDLE to LOAD_W or STREAM costs one cycle. The ready signal rises in the cycle after the valid was first seen in IDLE.
- Weight path: 1-cycle latency from acceptance to `row_load_en`. Back-to-back beats give consecutive one-hot strobes.
- Activation path: a token accepted at edge N has row r at `in_act_vec` during cycle N+r.
  - The array result for column c appears in cycle N+ARRAY_ROW+c.
  - `col_valid[c]` is high in exactly that cycle.
- Drain: for a last token accepted at edge N, `done` is high in cycle N+ARRAY_ROW+ARRAY_COL-1, together with `col_valid[ARRAY_COL-1]`.
- `a_last` on the first token is legal; the drain is the same.
- `en_compute` is high from the first STREAM cycle through the `done` cycle, then 0 in IDLE.

## Test plan
- **Reset:** reset, then idle for 5 cycles → all outputs stay 0, and `w_ready`/`a_ready` stay 0.
- **Weight load:** with ARRAY_ROW=12, drive 12 back-to-back beats with data row i = {ARRAY_COL{8'(i+1)}} → `row_load_en` shows 1,2,4,…,0x800 on consecutive cycles, each with the matching data. After the last beat the state is IDLE.
- **Skew and latency:** stream 32 tokens continuously, last on token 31. Check a golden model: row r equals token[t-r].r, and `col_valid[c]` pattern matches a 32-cycle run starting at cycle N0+ARRAY_ROW+c. `done` fires in cycle N31+ARRAY_ROW+ARRAY_COL-1.
- **Bubbles:** drop `a_valid` on every third cycle over 10 tokens → `in_act_vec` carries zeros in the gaps, `col_valid` has matching holes, and results remain correctly aligned.
- **Single token:** one token of all 8'h01 with `a_last` → `col_valid[c]` pulses once at N+ARRAY_ROW+c, and `done` fires at N+ARRAY_ROW+ARRAY_COL-1.
- **Mid-stream reset:** assert `rst_n`=0 during token 5 of 20 → all outputs are immediately 0. After release, a new load plus stream behaves exactly as in the skew-and-latency case.

Source files
------------

// File: rtl/sa_feeder.sv
// sa_feeder: front-end sequencer for systolic_array.
// Loads stationary weights one row per beat, streams activations with a
// triangular skew, flushes with zeros after the last token and tracks
// per-column result validity aligned to the array's psum outputs.

`ifndef ARRAY_ROW
`define ARRAY_ROW 12
`endif
`ifndef ARRAY_COL
`define ARRAY_COL 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sa_feeder #(
  parameter int unsigned ARRAY_ROW  = `ARRAY_ROW,
  parameter int unsigned ARRAY_COL  = `ARRAY_COL,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [ARRAY_COL*DATA_WIDTH-1:0] w_data,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [ARRAY_ROW*DATA_WIDTH-1:0] a_data,
  input  logic                            a_last,
  output logic [ARRAY_ROW-1:0]            row_load_en,
  output logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec,
  output logic                            en_compute,
  output logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec,
  output logic [ARRAY_COL-1:0]            col_valid,
  output logic                            busy,
  output logic                            done
);

  // Valid pipeline spans stage 0 plus ARRAY_ROW+ARRAY_COL-1 delay stages.
  localparam int unsigned VLD_D  = ARRAY_ROW + ARRAY_COL;
  localparam int unsigned WCNT_W = (ARRAY_ROW > 1) ? $clog2(ARRAY_ROW) : 1;
  localparam int unsigned DCNT_W = $clog2(ARRAY_ROW + ARRAY_COL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [WCNT_W-1:0]   w_cnt;
  logic [DCNT_W-1:0]   drain_cnt;
  logic [VLD_D-1:0]    vld_q;
  logic                w_accept_c;
  logic                a_accept_c;

  // Next-state decode and handshake qualification.
  always_comb begin
    next_state = state;
    w_accept_c = 1'b0;
    a_accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (w_valid) begin
          next_state = LOAD_W;
        end else if (a_valid) begin
          next_state = STREAM;
        end
      end
      LOAD_W: begin
        w_accept_c = w_valid & w_ready;
        if (w_accept_c && (w_cnt == WCNT_W'(ARRAY_ROW - 1))) begin
          next_state = IDLE;
        end
      end
      STREAM: begin
        a_accept_c = a_valid & a_ready;
        if (a_accept_c && a_last) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DCNT_W'(ARRAY_ROW + ARRAY_COL - 1)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered control outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ready    <= 1'b0;
      a_ready    <= 1'b0;
      en_compute <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      w_ready    <= (next_state == LOAD_W);
      a_ready    <= (next_state == STREAM);
      en_compute <= (next_state == STREAM) || (next_state == DRAIN);
      busy       <= (next_state != IDLE);
      done       <= (state == DRAIN) &&
                    (drain_cnt == DCNT_W'(ARRAY_ROW + ARRAY_COL - 2));
    end
  end

  // Weight beat counter; holds across gaps and wraps after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt <= '0;
    end else if (w_accept_c) begin
      w_cnt <= (w_cnt == WCNT_W'(ARRAY_ROW - 1)) ? '0 : w_cnt + WCNT_W'(1);
    end
  end

  // Drain counter; zero in the first DRAIN cycle, counts every cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state != DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DCNT_W'(1);
    end
  end

  // Weight load strobe and data, presented for one cycle per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_load_en   <= '0;
      in_weight_vec <= '0;
    end else if (w_accept_c) begin
      row_load_en   <= ARRAY_ROW'(1) << w_cnt;
      in_weight_vec <= w_data;
    end else begin
      row_load_en   <= '0;
      in_weight_vec <= '0;
    end
  end

  // Token valid pipeline; column c taps the stage ARRAY_ROW+c cycles back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[VLD_D-2:0], a_accept_c};
    end
  end

  assign col_valid = vld_q[VLD_D-1:ARRAY_ROW];

  // Per-row skew lines: row r holds r+1 registers, so row r lags row 0 by r.
  for (genvar r = 0; r < int'(ARRAY_ROW); r++) begin : g_skew
    logic [DATA_WIDTH-1:0] dl [r+1];

    // Capture the accepted element (or a zero bubble) and shift it down.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          dl[k] <= '0;
        end
      end else begin
        dl[0] <= a_accept_c ? a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= r; k++) begin
          dl[k] <= dl[k-1];
        end
      end
    end

    assign in_act_vec[r*DATA_WIDTH +: DATA_WIDTH] = dl[r];
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Testbench for sa_feeder: randomized streams checked against a
// cycle-indexed record of accepted beats.
`timescale 1ns/1ps

module tb_sa_feeder;

  localparam int ROW = 12;
  localparam int COL = 8;
  localparam int DW  = 8;
  localparam int AW  = ROW * DW;
  localparam int WW  = COL * DW;
  localparam int LAT = ROW + COL - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [WW-1:0] w_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] a_data = '0;
  logic          a_last = 1'b0;
  logic [ROW-1:0] row_load_en;
  logic [WW-1:0] in_weight_vec;
  logic          en_compute;
  logic [AW-1:0] in_act_vec;
  logic [COL-1:0] col_valid;
  logic          busy;
  logic          done;

  sa_feeder #(
    .ARRAY_ROW (ROW),
    .ARRAY_COL (COL),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .a_last       (a_last),
    .row_load_en  (row_load_en),
    .in_weight_vec(in_weight_vec),
    .en_compute   (en_compute),
    .in_act_vec   (in_act_vec),
    .col_valid    (col_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Cycle t is the interval following rising edge number t.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int            e;
    logic [AW-1:0] d;
  } tok_t;

  tok_t acc_q[$];
  int   last_edge;

  // Row r in cycle t shows element r of the token accepted at edge t-r.
  function automatic logic [AW-1:0] model_act(input int t);
    logic [AW-1:0] v = '0;
    for (int r = 0; r < ROW; r++)
      foreach (acc_q[i])
        if (acc_q[i].e == t - r) v[r*DW +: DW] = acc_q[i].d[r*DW +: DW];
    return v;
  endfunction

  // Column c is valid in cycle t iff a token was accepted at edge t-ROW-c.
  function automatic logic [COL-1:0] model_colv(input int t);
    logic [COL-1:0] v = '0;
    for (int c = 0; c < COL; c++)
      foreach (acc_q[i])
        if (acc_q[i].e == t - ROW - c) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [2+ROW+WW+1+AW+COL+2-1:0] all_outs();
    return {w_ready, a_ready, row_load_en, in_weight_vec, en_compute,
            in_act_vec, col_valid, busy, done};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) $display("FAIL reset_outs got=%h exp=0", all_outs());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (all_outs() !== '0) $display("FAIL idle_outs k=%0d got=%h exp=0", k, all_outs());
      else n_pass++;
    end
  endtask

  // Weight load: gaps=0 gives back-to-back beats with data {COL{i+1}}.
  task automatic run_wload(input bit gaps);
    int            t, t0, nacc, last_e;
    bit            ready_e, fin;
    logic [ROW-1:0] exp_rle;
    logic [WW-1:0] exp_wv, d;
    int            be [ROW];
    logic [WW-1:0] bd [ROW];
    nacc = 0; last_e = -1; fin = 1'b0;
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < 400; k++) begin
      t = cyc;
      ready_e = (t > t0) && (last_e < 0 || t < last_e);
      exp_rle = '0; exp_wv = '0;
      for (int b = 0; b < nacc; b++)
        if (be[b] == t) begin exp_rle[b] = 1'b1; exp_wv = bd[b]; end
      n_checks++;
      if (w_ready !== ready_e) $display("FAIL wl_w_ready cyc=%0d got=%b exp=%b", t, w_ready, ready_e);
      else n_pass++;
      n_checks++;
      if (busy !== ready_e) $display("FAIL wl_busy cyc=%0d got=%b exp=%b", t, busy, ready_e);
      else n_pass++;
      n_checks++;
      if (row_load_en !== exp_rle) $display("FAIL wl_row_load_en cyc=%0d got=%h exp=%h", t, row_load_en, exp_rle);
      else n_pass++;
      n_checks++;
      if (in_weight_vec !== exp_wv) $display("FAIL wl_weight_vec cyc=%0d got=%h exp=%h", t, in_weight_vec, exp_wv);
      else n_pass++;
      n_checks++;
      if ({a_ready, en_compute} !== 2'b00) $display("FAIL wl_act_side cyc=%0d got=%b exp=00", t, {a_ready, en_compute});
      else n_pass++;
      if (last_e >= 0 && t > last_e) begin fin = 1'b1; break; end
      if (nacc < ROW && (!gaps || k == 0 || $urandom_range(0, 2) != 0)) begin
        if (gaps) for (int c = 0; c < COL; c++) d[c*DW +: DW] = 8'($urandom);
        else d = {COL{8'(nacc + 1)}};
        w_valid = 1'b1; w_data = d;
        if (ready_e) begin
          be[nacc] = t + 1; bd[nacc] = d; nacc++;
          if (nacc == ROW) last_e = t + 1;
        end
      end else begin
        w_valid = 1'b0; w_data = '0;
      end
      a_valid = gaps && (k == 0);
      @(negedge clk);
    end
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0;
    if (!fin) begin
      n_checks++;
      $display("FAIL wl_timeout got=%0d beats exp=%0d", nacc, ROW);
    end
  endtask

  // Activation stream of ntok tokens; optional bubbles, all-ones data,
  // or an asynchronous reset once rst_after tokens have been accepted.
  task automatic run_stream(input int ntok, input bit bubbles, input bit ones, input int rst_after);
    int            t, start_t, sent;
    bit            ready_e, exp_en, exp_done, fin;
    logic [AW-1:0] d, exp_act;
    logic [COL-1:0] exp_cv;
    acc_q.delete(); last_edge = -1; sent = 0; fin = 1'b0;
    @(negedge clk);
    start_t = cyc;
    for (int k = 0; k < 600; k++) begin
      t = cyc;
      ready_e  = (t > start_t) && (last_edge < 0 || t < last_edge);
      exp_en   = (t > start_t) && (last_edge < 0 || t <= last_edge + LAT);
      exp_done = (last_edge >= 0) && (t == last_edge + LAT);
      exp_act  = model_act(t);
      exp_cv   = model_colv(t);
      n_checks++;
      if (a_ready !== ready_e) $display("FAIL st_a_ready cyc=%0d got=%b exp=%b", t, a_ready, ready_e);
      else n_pass++;
      n_checks++;
      if (en_compute !== exp_en) $display("FAIL st_en_compute cyc=%0d got=%b exp=%b", t, en_compute, exp_en);
      else n_pass++;
      n_checks++;
      if (busy !== exp_en) $display("FAIL st_busy cyc=%0d got=%b exp=%b", t, busy, exp_en);
      else n_pass++;
      n_checks++;
      if (done !== exp_done) $display("FAIL st_done cyc=%0d got=%b exp=%b", t, done, exp_done);
      else n_pass++;
      n_checks++;
      if (in_act_vec !== exp_act) $display("FAIL st_act_vec cyc=%0d got=%h exp=%h", t, in_act_vec, exp_act);
      else n_pass++;
      n_checks++;
      if (col_valid !== exp_cv) $display("FAIL st_col_valid cyc=%0d got=%b exp=%b", t, col_valid, exp_cv);
      else n_pass++;
      n_checks++;
      if ({w_ready, row_load_en} !== '0) $display("FAIL st_weight_side cyc=%0d got=%h exp=0", t, {w_ready, row_load_en});
      else n_pass++;
      if (last_edge >= 0 && t > last_edge + LAT) begin fin = 1'b1; break; end
      if (rst_after >= 0 && sent == rst_after) begin
        rst_n = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_data = '0;
        #1;
        n_checks++;
        if (all_outs() !== '0) $display("FAIL midreset_outs cyc=%0d got=%h exp=0", t, all_outs());
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) $display("FAIL midreset_hold cyc=%0d got=%h exp=0", cyc, all_outs());
        else n_pass++;
        rst_n = 1'b1;
        fin = 1'b1;
        break;
      end
      if (sent < ntok && !(bubbles && (k % 3 == 2))) begin
        for (int r = 0; r < ROW; r++) d[r*DW +: DW] = ones ? 8'h01 : 8'($urandom);
        a_valid = 1'b1; a_data = d; a_last = (sent == ntok - 1);
        if (ready_e) begin
          acc_q.push_back('{e: t + 1, d: d});
          sent++;
          if (a_last) last_edge = t + 1;
        end
      end else begin
        a_valid = 1'b0; a_last = 1'b0; a_data = '0;
      end
      @(negedge clk);
    end
    a_valid = 1'b0; a_last = 1'b0; a_data = '0;
    if (!fin) begin
      n_checks++;
      $display("FAIL st_timeout got=%0d tokens exp=%0d", sent, ntok);
    end
  endtask

  task automatic test_weight_load();
    run_wload(1'b0);
  endtask

  task automatic test_weight_gaps();
    run_wload(1'b1);
  endtask

  task automatic test_skew();
    run_stream(32, 1'b0, 1'b0, -1);
  endtask

  task automatic test_bubbles();
    run_stream(10, 1'b1, 1'b0, -1);
  endtask

  task automatic test_single_token();
    run_stream(1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_midstream_reset();
    run_stream(20, 1'b0, 1'b0, 5);
    run_wload(1'b0);
    run_stream(32, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_weight_gaps();
    test_skew();
    test_bubbles();
    test_single_token();
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
